fb_fill_dma: RTL and testbench



---
 rtl/fb_fill_dma_pkg.sv | 29 ++
 rtl/fb_rect_clip.sv | 42 ++++
 rtl/fb_fill_dma.sv | 224 ++++++++++++++++++++++
 tb/tb_fb_fill_dma.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_fill_dma_pkg.sv
// -----------------------------------------------------------------------------
// fb_fill_dma_pkg
// Shared definitions for the framebuffer rectangle-fill engine and its helpers:
// framebuffer geometry, byte-strobe constant, row pitch, FSM state encoding and
// the pixel-to-bus-word packing helper.
// No ports (package).
// -----------------------------------------------------------------------------
package fb_fill_dma_pkg;

    localparam int         FB_XRES    = 80;          // pixels (words) per row
    localparam int         FB_YRES    = 60;          // rows
    localparam logic [3:0] WSTRB_WORD = 4'hF;        // full 32-bit word write
    localparam int         ROW_BYTES  = FB_XRES * 4; // byte pitch of one row

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WAIT_VBL = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_STEP     = 3'd4,
        ST_FIN      = 3'd5
    } fill_state_e;

    // RGB888 pixel placed in the low three bytes of a bus word.
    function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
        return {8'h00, rgb};
    endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// -----------------------------------------------------------------------------
// fb_rect_clip
// Combinational clip of a rectangle against the framebuffer bounds.
// Ports:
//   x0, y0  in  8   top-left corner
//   w,  h   in  8   requested width / height
//   ew, eh  out 8   effective (clipped) width / height
//   reject  out 1   origin lies outside the framebuffer
//   empty   out 1   clipped rectangle has no pixels
// Arithmetic is 9 bits wide so XRES-x0 and the comparisons never overflow.
// ew/eh are only meaningful when reject is low.
// -----------------------------------------------------------------------------
module fb_rect_clip
    import fb_fill_dma_pkg::*;
#(
    parameter int XRES = FB_XRES,
    parameter int YRES = FB_YRES
) (
    input  logic [7:0] x0,
    input  logic [7:0] y0,
    input  logic [7:0] w,
    input  logic [7:0] h,
    output logic [7:0] ew,
    output logic [7:0] eh,
    output logic       reject,
    output logic       empty
);

    logic [8:0] rem_x;
    logic [8:0] rem_y;

    always_comb begin
        rem_x  = 9'(XRES) - {1'b0, x0};
        rem_y  = 9'(YRES) - {1'b0, y0};
        reject = ({1'b0, x0} >= 9'(XRES)) || ({1'b0, y0} >= 9'(YRES));
        // min(w, XRES-x0): the result is never larger than w, so 8 bits suffice.
        ew     = ({1'b0, w} < rem_x) ? w : rem_x[7:0];
        eh     = ({1'b0, h} < rem_y) ? h : rem_y[7:0];
        empty  = (ew == 8'd0) || (eh == 8'd0);
    end

endmodule

// File: rtl/fb_fill_dma.sv
// -----------------------------------------------------------------------------
// fb_fill_dma
// Bus-master rectangle fill: writes one 32-bit word per pixel of a clipped
// rectangle into an XRES x YRES framebuffer through the iomem master port.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start                   one-cycle request, sampled only in IDLE
//   cfg_base/x0/y0/w/h/color fill description, latched on accepted start
//   vblank                  vertical blank (used only with FB_FILL_VBLANK_SYNC_EN)
//   busy, done, err         status: busy while filling, done pulse, err with done
//   mem_valid/ready/wstrb/addr/wdata  iomem master port
//   dbg_state               current FSM state for observation
// Optional build macro: FB_FILL_VBLANK_SYNC_EN -- gates bus requests on vblank
// and inserts a WAIT_VBL state between SETUP and ISSUE.
//
// Handshake: a beat is offered by holding mem_valid with stable addr/wdata/
// wstrb; it completes on the first rising edge that samples mem_ready=1 while
// mem_valid=1. mem_valid then drops for exactly one cycle (STEP) so the
// responder's registered ready can clear. mem_ready is ignored at other times.
// -----------------------------------------------------------------------------
module fb_fill_dma
    import fb_fill_dma_pkg::*;
#(
    parameter int XRES   = FB_XRES,
    parameter int YRES   = FB_YRES,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       cfg_base,
    input  logic [7:0]        cfg_x0,
    input  logic [7:0]        cfg_y0,
    input  logic [7:0]        cfg_w,
    input  logic [7:0]        cfg_h,
    input  logic [23:0]       cfg_color,
    input  logic              vblank,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output fill_state_e       dbg_state
);

    // Bytes between vertically adjacent pixels (word size taken from the
    // package pitch so both stay consistent).
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(XRES * (ROW_BYTES / FB_XRES));

    fill_state_e       state_q, state_d;

    logic [ADDR_W-1:0] lat_base;
    logic [7:0]        lat_x0, lat_y0, lat_w, lat_h;
    logic [23:0]       lat_color;

    logic [7:0]        col_q, row_q;
    logic [ADDR_W-1:0] row_addr_q;
    logic              err_q;

    logic [7:0]        ew, eh;
    logic              reject, empty;
    logic              last_col, last_row;
    logic [ADDR_W-1:0] pix_off, first_addr;
    logic              issue_ok;

    // Clip works on the latched request, which is stable for the whole fill.
    fb_rect_clip #(
        .XRES (XRES),
        .YRES (YRES)
    ) u_clip (
        .x0     (lat_x0),
        .y0     (lat_y0),
        .w      (lat_w),
        .h      (lat_h),
        .ew     (ew),
        .eh     (eh),
        .reject (reject),
        .empty  (empty)
    );

    assign last_col   = (col_q == ew - 8'd1);
    assign last_row   = (row_q == eh - 8'd1);
    assign pix_off    = ADDR_W'(lat_y0) * ADDR_W'(XRES) + ADDR_W'(lat_x0);
    assign first_addr = lat_base + (pix_off << 2);

`ifdef FB_FILL_VBLANK_SYNC_EN
    // Remembers that a beat was already offered, so a falling vblank cannot
    // withdraw mem_valid before the responder has acknowledged it.
    logic held_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q <= 1'b0;
        end else begin
            held_q <= mem_valid & ~mem_ready;
        end
    end

    assign issue_ok = vblank | held_q;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign issue_ok      = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (reject || empty) begin
                    state_d = ST_FIN;
                end else begin
`ifdef FB_FILL_VBLANK_SYNC_EN
                    state_d = ST_WAIT_VBL;
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_WAIT_VBL: begin
`ifdef FB_FILL_VBLANK_SYNC_EN
                if (vblank) state_d = ST_ISSUE;
`else
                state_d = ST_ISSUE;
`endif
            end
            ST_ISSUE: begin
                if (mem_valid && mem_ready) state_d = ST_STEP;
            end
            ST_STEP: begin
                state_d = (last_col && last_row) ? ST_FIN : ST_ISSUE;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latch, error flag and pixel walk counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_base   <= '0;
            lat_x0     <= '0;
            lat_y0     <= '0;
            lat_w      <= '0;
            lat_h      <= '0;
            lat_color  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        lat_base  <= ADDR_W'(cfg_base);
                        lat_x0    <= cfg_x0;
                        lat_y0    <= cfg_y0;
                        lat_w     <= cfg_w;
                        lat_h     <= cfg_h;
                        lat_color <= cfg_color;
                        err_q     <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    err_q      <= reject;
                    row_addr_q <= first_addr;
                    col_q      <= '0;
                    row_q      <= '0;
                end
                ST_STEP: begin
                    if (!last_col) begin
                        col_q <= col_q + 8'd1;
                    end else if (!last_row) begin
                        col_q      <= '0;
                        row_q      <= row_q + 8'd1;
                        row_addr_q <= row_addr_q + ROW_STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus outputs are decoded from state, so reset removes mem_valid at once.
    always_comb begin
        mem_valid = 1'b0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_ISSUE) begin
            mem_valid = issue_ok;
            mem_wstrb = WSTRB_WORD;
            mem_addr  = row_addr_q + (ADDR_W'(col_q) << 2);
            mem_wdata = pack_pixel(lat_color);
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_fill_dma.sv
// -----------------------------------------------------------------------------
// tb_fb_fill_dma
// Directed testbench for fb_fill_dma: a registered-ready responder that logs
// every accepted write, and one task per scenario with inline comparisons.
// -----------------------------------------------------------------------------
module tb_fb_fill_dma;
    import fb_fill_dma_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic [31:0] cfg_base  = '0;
    logic [7:0]  cfg_x0    = '0;
    logic [7:0]  cfg_y0    = '0;
    logic [7:0]  cfg_w     = '0;
    logic [7:0]  cfg_h     = '0;
    logic [23:0] cfg_color = '0;
    logic        vblank    = 1'b0;
    logic        mem_ready = 1'b0;
    logic        busy, done, err, mem_valid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    fill_state_e dbg_state;

    initial forever #5 clk = ~clk;

    fb_fill_dma dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_base  (cfg_base),
        .cfg_x0    (cfg_x0),
        .cfg_y0    (cfg_y0),
        .cfg_w     (cfg_w),
        .cfg_h     (cfg_h),
        .cfg_color (cfg_color),
        .vblank    (vblank),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- responder / monitor ----------------
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_strb_q[$];
    int          gap_q[$];
    int          beat_idx, valid_cycles, unstable_cnt, done_cnt, done_cyc;
    int          first_valid_cyc = -1;
    int          low_run, wait_cnt;
    logic        done_err, had_beat;
    logic [31:0] hold_addr, hold_data;
    logic [3:0]  hold_strb;
    logic        clr_req  = 1'b0;
    logic        clr_seen = 1'b0;
    int          bp_beat  = -1;
    int          bp_lat   = 6;

    initial forever begin
        @(negedge clk);
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            wr_addr_q.delete();
            wr_data_q.delete();
            wr_strb_q.delete();
            gap_q.delete();
            beat_idx        = 0;
            valid_cycles    = 0;
            unstable_cnt    = 0;
            done_cnt        = 0;
            first_valid_cyc = -1;
            had_beat        = 1'b0;
            low_run         = 0;
        end
        if (reset) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else begin
            // ready is a one-cycle registered pulse
            if (mem_ready) begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
                had_beat  = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = err;
            end
            if (mem_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (wait_cnt == 0) begin
                    hold_addr = mem_addr;
                    hold_data = mem_wdata;
                    hold_strb = mem_wstrb;
                    if (had_beat) gap_q.push_back(low_run);
                end else if (mem_addr !== hold_addr || mem_wdata !== hold_data ||
                             mem_wstrb !== hold_strb) begin
                    unstable_cnt++;
                end
                low_run = 0;
                wait_cnt++;
                if (wait_cnt > ((beat_idx == bp_beat) ? bp_lat : 1)) begin
                    mem_ready = 1'b1;
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                    wr_strb_q.push_back(mem_wstrb);
                    beat_idx++;
                end
            end else begin
                low_run++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_log();
        clr_req = ~clr_req;
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] w, input logic [7:0] h, input logic [23:0] color);
        @(posedge clk); #2;
        cfg_base  = base;
        cfg_x0    = x0;
        cfg_y0    = y0;
        cfg_w     = w;
        cfg_h     = h;
        cfg_color = color;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done_cnt == 0 && t < budget) begin
            @(posedge clk); #2;
            t++;
        end
        n_checks++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", budget);
        end
        @(posedge clk); #2;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t = 0;
        while (beat_idx < n && t < budget) begin
            @(posedge clk); #2;
            t++;
        end
        n_checks++;
        if (beat_idx < n) begin
            n_fail++;
            $display("FAIL beat_timeout: got %0d beats, required %0d", beat_idx, n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({busy, done, err, mem_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000", {busy, done, err, mem_valid});
        end
        n_checks++;
        if (mem_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_wstrb: got %h required 0", mem_wstrb);
        end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr_data: got %h/%h required 0/0", mem_addr, mem_wdata);
        end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy %b state %0d required 0/IDLE", busy, dbg_state);
        end
    endtask

    task automatic test_single_pixel();
        clear_log();
        do_start(32'h1000_0000, 8'd0, 8'd0, 8'd1, 8'd1, 24'hFF0000);
        wait_done(100);
        n_checks++;
        if (wr_addr_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d writes required 1", wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[0] !== 32'h1000_0000 || wr_data_q[0] !== 32'h00FF_0000 ||
                wr_strb_q[0] !== 4'hF) begin
                n_fail++;
                $display("FAIL single_beat: got %h/%h/%h required 10000000/00ff0000/f",
                         wr_addr_q[0], wr_data_q[0], wr_strb_q[0]);
            end
        end
        n_checks++;
        if (first_valid_cyc - start_cyc != 2) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles required 2", first_valid_cyc - start_cyc);
        end
        n_checks++;
        if (done_cnt != 1 || done_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got %0d pulses err %b required 1 pulse err 0", done_cnt, done_err);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_right_clip();
        logic [31:0] exp_addr[4];
        exp_addr[0] = 32'h1000_0138;
        exp_addr[1] = 32'h1000_013C;
        exp_addr[2] = 32'h1000_0278;
        exp_addr[3] = 32'h1000_027C;
        clear_log();
        do_start(32'h1000_0000, 8'd78, 8'd0, 8'd4, 8'd2, 24'h123456);
        wait_done(200);
        n_checks++;
        if (wr_addr_q.size() != 4) begin
            n_fail++;
            $display("FAIL clip_count: got %0d writes required 4", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== 32'h0012_3456) begin
                    n_fail++;
                    $display("FAIL clip_beat%0d: got %h/%h required %h/00123456",
                             i, wr_addr_q[i], wr_data_q[i], exp_addr[i]);
                end
            end
        end
        n_checks++;
        if (gap_q.size() != 3) begin
            n_fail++;
            $display("FAIL clip_gaps: got %0d gaps required 3", gap_q.size());
        end
        // bottom-right corner: clipped down to a single pixel
        clear_log();
        do_start(32'h2000_0000, 8'd79, 8'd59, 8'd5, 8'd5, 24'h00_00FF);
        wait_done(100);
        n_checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h2000_4AFC) begin
            n_fail++;
            $display("FAIL corner_clip: got %0d writes first %h required 1 write at 20004afc",
                     wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'h0);
        end
    endtask

    task automatic test_empty_reject();
        clear_log();
        do_start(32'h1000_0000, 8'd10, 8'd10, 8'd0, 8'd5, 24'hAAAAAA);
        wait_done(50);
        n_checks++;
        if (valid_cycles != 0 || done_cyc - start_cyc != 2 || done_err !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_w0: got valid %0d latency %0d err %b required 0/2/0",
                     valid_cycles, done_cyc - start_cyc, done_err);
        end
        clear_log();
        do_start(32'h1000_0000, 8'd80, 8'd0, 8'd1, 8'd1, 24'hAAAAAA);
        wait_done(50);
        n_checks++;
        if (valid_cycles != 0 || done_cyc - start_cyc != 2 || done_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_x80: got valid %0d latency %0d err %b required 0/2/1",
                     valid_cycles, done_cyc - start_cyc, done_err);
        end
        clear_log();
        do_start(32'h1000_0000, 8'd0, 8'd60, 8'd1, 8'd1, 24'hAAAAAA);
        wait_done(50);
        n_checks++;
        if (valid_cycles != 0 || done_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_y60: got valid %0d err %b required 0/1", valid_cycles, done_err);
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_held: got %b required 1", err);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr[3];
        exp_addr[0] = 32'h0000_04C8;
        exp_addr[1] = 32'h0000_04CC;
        exp_addr[2] = 32'h0000_04D0;
        clear_log();
        bp_beat = 1;
        do_start(32'h0000_0100, 8'd2, 8'd3, 8'd3, 8'd1, 24'hABCDEF);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_start: got err %b busy %b required 0/1", err, busy);
        end
        wait_beats(1, 100);
        // a start pulse while busy must be ignored
        cfg_x0 = 8'd5;
        cfg_y0 = 8'd5;
        cfg_w  = 8'd1;
        cfg_h  = 8'd1;
        start  = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(200);
        bp_beat = -1;
        n_checks++;
        if (wr_addr_q.size() != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d writes required 3", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== 32'h00AB_CDEF ||
                    wr_strb_q[i] !== 4'hF) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got %h/%h/%h required %h/00abcdef/f",
                             i, wr_addr_q[i], wr_data_q[i], wr_strb_q[i], exp_addr[i]);
                end
            end
        end
        n_checks++;
        if (unstable_cnt != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d changes while valid required 0", unstable_cnt);
        end
        n_checks++;
        if (valid_cycles != 11) begin
            n_fail++;
            $display("FAIL bp_valid_cycles: got %0d required 11", valid_cycles);
        end
        n_checks++;
        if (gap_q.size() != 2) begin
            n_fail++;
            $display("FAIL bp_gap_count: got %0d required 2", gap_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (gap_q[i] != 1) begin
                    n_fail++;
                    $display("FAIL bp_gap%0d: got %0d idle cycles required 1", i, gap_q[i]);
                end
            end
        end
        repeat (10) @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b0 || done_cnt != 1 || wr_addr_q.size() != 3) begin
            n_fail++;
            $display("FAIL bp_ignored_start: got busy %b done %0d writes %0d required 0/1/3",
                     busy, done_cnt, wr_addr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        do_start(32'h1000_0000, 8'd0, 8'd0, 8'd4, 8'd4, 24'h555555);
        wait_beats(3, 100);
        @(posedge clk); #2;
        n_checks++;
        if (mem_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_precond: got valid %b required 1", mem_valid);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL mid_async: got valid %b busy %b state %0d required 0/0/IDLE",
                     mem_valid, busy, dbg_state);
        end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (done_cnt != 0 || wr_addr_q.size() != 3) begin
            n_fail++;
            $display("FAIL mid_abandon: got done %0d writes %0d required 0/3", done_cnt, wr_addr_q.size());
        end
        clear_log();
        do_start(32'h1000_0000, 8'd1, 8'd1, 8'd1, 8'd1, 24'h00FF00);
        wait_done(100);
        n_checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h1000_0144 || done_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_restart: got %0d writes first %h err %b required 1 at 10000144 err 0",
                     wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'h0, done_err);
        end
    endtask

`ifdef FB_FILL_VBLANK_SYNC_EN
    task automatic test_vblank();
        clear_log();
        vblank = 1'b0;
        do_start(32'h0000_0000, 8'd0, 8'd0, 8'd2, 8'd1, 24'h010203);
        repeat (10) @(posedge clk);
        #2;
        n_checks++;
        if (valid_cycles != 0 || busy !== 1'b1 || dbg_state !== ST_WAIT_VBL) begin
            n_fail++;
            $display("FAIL vbl_hold: got valid %0d busy %b state %0d required 0/1/WAIT_VBL",
                     valid_cycles, busy, dbg_state);
        end
        vblank = 1'b1;
        wait_beats(1, 50);
        vblank = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        n_checks++;
        if (wr_addr_q.size() != 1 || mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL vbl_gate: got %0d writes valid %b required 1/0", wr_addr_q.size(), mem_valid);
        end
        vblank = 1'b1;
        wait_done(100);
        n_checks++;
        if (wr_addr_q.size() != 2 || wr_addr_q[1] !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL vbl_resume: got %0d writes required 2 ending at 00000004", wr_addr_q.size());
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
`ifdef FB_FILL_VBLANK_SYNC_EN
        vblank = 1'b1;
`endif
        test_reset();
        test_single_pixel();
        test_right_clip();
        test_empty_reject();
        test_backpressure();
        test_reset_mid();
`ifdef FB_FILL_VBLANK_SYNC_EN
        test_vblank();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
